// File: rtl/jtdd_vmeasure.sv
// jtdd_vmeasure: video timing receiver. Measures total/active pixels per line
// and total/active lines per frame, raises `locked` once three consecutive
// frames agree, and optionally computes a per-frame pixel CRC.
// Optional feature macro: JTDD_VMEASURE_CRC_EN (CRC-16-CCITT over {red,green,blue}).
module jtdd_vmeasure #(
   parameter int HW = 9,
   parameter int VW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic          LHBL,
   input  logic          LVBL,
   input  logic          HS,
   input  logic          VS,
   input  logic [3:0]    red,
   input  logic [3:0]    green,
   input  logic [3:0]    blue,
   output logic [HW-1:0] h_total,
   output logic [HW-1:0] h_active,
   output logic [VW-1:0] v_total,
   output logic [VW-1:0] v_active,
   output logic [15:0]   frame_crc,
   output logic          frame_done,
   output logic          locked,
   output logic          ovf
);

   typedef enum logic [1:0] {WAIT0, WAIT1, RUN} state_t;

   localparam logic [HW-1:0] HMAX = '1;
   localparam logic [VW-1:0] VMAX = '1;

   state_t        state, state_nx;
   logic          hs_l, vs_l, lhbl_l;
   logic          hs_rise, vs_rise, lhbl_rise;
   logic          latch;
   logic [HW-1:0] hcnt, hcnt_nx, hact, hact_nx;
   logic [HW-1:0] hlast, hlast_nx, hact_last, hact_last_nx;
   logic [VW-1:0] vcnt, vcnt_nx, vact, vact_nx;
   logic          sat, sat_nx;
   logic [1:0]    mcnt;
   logic          tuple_match;

   // Edge detection is qualified by pxl_cen so sync activity between enables is ignored
   assign hs_rise   = pxl_cen & HS   & ~hs_l;
   assign vs_rise   = pxl_cen & VS   & ~vs_l;
   assign lhbl_rise = pxl_cen & LHBL & ~lhbl_l;

   assign locked = (mcnt == 2'd2);

   // Measurement FSM: discard everything up to the first VS, then latch on every VS
   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      state_nx = state;
      latch    = 1'b0;
      case (state)
         WAIT0: if (vs_rise) state_nx = WAIT1;
         WAIT1: if (vs_rise) begin
            state_nx = RUN;
            latch    = 1'b1;
         end
         RUN:   latch = vs_rise;
         default: state_nx = WAIT0;
      endcase
   end

   // Next values of the saturating line/frame counters, current pixel included
   always_comb begin
      hcnt_nx      = hcnt;
      hact_nx      = hact;
      hlast_nx     = hlast;
      hact_last_nx = hact_last;
      vcnt_nx      = vcnt;
      vact_nx      = vact;
      sat_nx       = sat;
      if (pxl_cen) begin
         if (hs_rise) begin
            hcnt_nx      = HW'(1);
            hact_nx      = HW'(LHBL);
            hlast_nx     = hcnt;
            hact_last_nx = hact;
            if (vcnt == VMAX) sat_nx = 1'b1;
            else              vcnt_nx = vcnt + VW'(1);
         end else begin
            if (hcnt == HMAX) sat_nx = 1'b1;
            else              hcnt_nx = hcnt + HW'(1);
            if (LHBL) begin
               if (hact == HMAX) sat_nx = 1'b1;
               else              hact_nx = hact + HW'(1);
            end
         end
         if (lhbl_rise && LVBL) begin
            if (vact == VMAX) sat_nx = 1'b1;
            else              vact_nx = vact + VW'(1);
         end
      end
   end

   assign tuple_match = (hlast_nx == h_total) && (hact_last_nx == h_active) &&
                        (vcnt_nx == v_total)  && (vact_nx == v_active);

   // Counter, output and lock state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT0;
         hs_l       <= 1'b0;
         vs_l       <= 1'b0;
         lhbl_l     <= 1'b0;
         hcnt       <= '0;
         hact       <= '0;
         hlast      <= '0;
         hact_last  <= '0;
         vcnt       <= '0;
         vact       <= '0;
         sat        <= 1'b0;
         mcnt       <= 2'd0;
         h_total    <= '0;
         h_active   <= '0;
         v_total    <= '0;
         v_active   <= '0;
         ovf        <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values computed above.
         state      <= state_nx;
         frame_done <= latch;
         if (pxl_cen) begin
            hs_l   <= HS;
            vs_l   <= VS;
            lhbl_l <= LHBL;
         end
         hcnt      <= hcnt_nx;
         hact      <= hact_nx;
         hlast     <= hlast_nx;
         hact_last <= hact_last_nx;
         if (vs_rise) begin
            vcnt <= '0;
            vact <= '0;
            sat  <= 1'b0;
         end else begin
            vcnt <= vcnt_nx;
            vact <= vact_nx;
            sat  <= sat_nx;
         end
         if (latch) begin
            h_total  <= hlast_nx;
            h_active <= hact_last_nx;
            v_total  <= vcnt_nx;
            v_active <= vact_nx;
            ovf      <= sat_nx;
            if (!tuple_match || sat_nx) mcnt <= 2'd0;
            else if (mcnt != 2'd2)      mcnt <= mcnt + 2'd1;
         end
      end
   end

`ifdef JTDD_VMEASURE_CRC_EN
   logic [15:0] crc, crc_nx;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] w);
      logic [15:0] r;
      r = c;
      for (int i = 11; i >= 0; i--) begin
         if (r[15] ^ w[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   // One 12-bit word per visible pixel, unrolled into a single clock
   always_comb begin
      crc_nx = crc;
      if (pxl_cen && LHBL && LVBL) crc_nx = crc_step(crc, {red, green, blue});
   end

   // CRC accumulator restarts after each frame latch
   always_ff @(posedge clk) begin
      if (rst) begin
         crc       <= 16'hFFFF;
         frame_crc <= '0;
      end else begin
         crc <= vs_rise ? 16'hFFFF : crc_nx;
         if (latch) frame_crc <= crc_nx;
      end
   end
`else
   logic unused_colour;
   assign unused_colour = ^{red, green, blue};
   assign frame_crc     = '0;
`endif

endmodule

// File: tb/tb_jtdd_vmeasure.sv
// tb_jtdd_vmeasure: randomized frame generator with a frame-level reference
// model. Uses a scaled-down raster (40 px lines, 20 line frames, HW=VW=6) so
// that saturation is reachable with short lines. Random pxl_cen gaps carry
// random junk on every sync/blank/colour input.
module tb_jtdd_vmeasure;

   localparam int HW   = 6;
   localparam int VW   = 6;
   localparam int HMAX = (1 << HW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pxl_cen = 1'b0;
   logic          LHBL = 1'b0, LVBL = 1'b0, HS = 1'b0, VS = 1'b0;
   logic [3:0]    red = '0, green = '0, blue = '0;
   logic [HW-1:0] h_total, h_active;
   logic [VW-1:0] v_total, v_active;
   logic [15:0]   frame_crc;
   logic          frame_done, locked, ovf;

   always #5 clk = ~clk;

   jtdd_vmeasure #(.HW(HW), .VW(VW)) dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
      .HS(HS), .VS(VS), .red(red), .green(green), .blue(blue),
      .h_total(h_total), .h_active(h_active), .v_total(v_total),
      .v_active(v_active), .frame_crc(frame_crc), .frame_done(frame_done),
      .locked(locked), .ovf(ovf)
   );

   typedef struct {
      int h_total, h_active, v_total, v_active, crc, ovf, locked;
   } frame_t;

   int     checks = 0, errors = 0;
   frame_t exp_q[$];
   frame_t cur, prev, last_exp;
   int     mcnt_m = 0, vs_seen = 0, pushed = 0, done_cnt = 0;
   logic   prev_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int crc_word(input int c, input logic [11:0] w);
      logic [15:0] r;
      r = c[15:0];
      for (int i = 11; i >= 0; i--) begin
         if (r[15] ^ w[i]) r = (r << 1) ^ 16'h1021;
         else              r = r << 1;
      end
      return int'(r);
   endfunction

   function automatic int min_h(input int v);
      return (v > HMAX) ? HMAX : v;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      mcnt_m   = 0;
      vs_seen  = 0;
      prev     = '{default: 0};
      last_exp = '{default: 0};
      cur      = '{default: 0};
   endtask

   // A VS rise closes the previous frame; frames before the second VS are discarded
   task automatic frame_start();
      frame_t e;
      bit     same;
      if (vs_seen > 0) begin
         e    = cur;
         same = (e.h_total == prev.h_total) && (e.h_active == prev.h_active) &&
                (e.v_total == prev.v_total) && (e.v_active == prev.v_active);
         if (!same || e.ovf != 0) mcnt_m = 0;
         else if (mcnt_m < 2)     mcnt_m++;
         e.locked = (mcnt_m == 2) ? 1 : 0;
`ifndef JTDD_VMEASURE_CRC_EN
         e.crc = 0;
`endif
         prev = e;
         exp_q.push_back(e);
         pushed++;
      end
      vs_seen++;
      cur     = '{default: 0};
      cur.crc = 16'hFFFF;
   endtask

   // Random idle clocks carry junk on every input, then one enabled pixel
   task automatic drive_pixel(input logic hs, input logic vs, input logic lhbl,
                              input logic lvbl, input logic [11:0] rgb);
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         pxl_cen = 1'b0;
         HS = 1'($urandom); VS = 1'($urandom);
         LHBL = 1'($urandom); LVBL = 1'($urandom);
         {red, green, blue} = 12'($urandom);
      end
      @(posedge clk);
      #1;
      pxl_cen = 1'b1;
      HS = hs; VS = vs; LHBL = lhbl; LVBL = lvbl;
      {red, green, blue} = rgb;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_h_total"},    32'(h_total),    0);
      check({pfx, "_h_active"},   32'(h_active),   0);
      check({pfx, "_v_total"},    32'(v_total),    0);
      check({pfx, "_v_active"},   32'(v_active),   0);
      check({pfx, "_frame_crc"},  32'(frame_crc),  0);
      check({pfx, "_frame_done"}, 32'(frame_done), 0);
      check({pfx, "_locked"},     32'(locked),     0);
      check({pfx, "_ovf"},        32'(ovf),        0);
   endtask

   // One-clock reset pulse in the middle of a frame
   task automatic mid_reset();
      @(posedge clk);
      #1;
      pxl_cen = 1'b0;
      rst     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("midrst");
      rst = 1'b0;
      model_reset();
   endtask

   // pxl_cen held low for 10 clocks while HS toggles: nothing may move
   task automatic hold_test();
      @(posedge clk);
      #1;
      pxl_cen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         HS = ~HS;
         VS = 1'($urandom);
      end
      @(negedge clk);
      check("hold_h_total",  32'(h_total),  last_exp.h_total);
      check("hold_v_total",  32'(v_total),  last_exp.v_total);
      check("hold_v_active", 32'(v_active), last_exp.v_active);
      check("hold_locked",   32'(locked),   last_exp.locked);
   endtask

   task automatic drive_frame(input int nl, input int len, input int act, input int last_len,
                              input bit zero_col, input int rst_line, input int hold_line);
      int          ll, vact_n;
      logic        lvbl, lhbl;
      logic [11:0] rgb;
      vact_n = 0;
      for (int l = 0; l < nl; l++) begin
         if (l == rst_line) mid_reset();
         ll   = (l == nl - 1) ? last_len : len;
         lvbl = (l >= 3) && (l < nl - 3);
         if (lvbl) vact_n++;
         for (int p = 0; p < ll; p++) begin
            if (l == 0 && p == 0) frame_start();
            lhbl = (p >= 8) && (p < 8 + act);
            rgb  = zero_col ? 12'h000 : 12'($urandom);
            if (lhbl && lvbl) cur.crc = crc_word(cur.crc, rgb);
            drive_pixel(p < 4, l < 2, lhbl, lvbl, rgb);
            if (l == hold_line && p == 20) hold_test();
         end
      end
      cur.h_total  = min_h(last_len);
      cur.h_active = min_h(act);
      cur.v_total  = nl;
      cur.v_active = vact_n;
      cur.ovf      = (last_len > HMAX || len > HMAX) ? 1 : 0;
   endtask

   // Frame-done monitor: compares each latched frame against the model queue
   always @(negedge clk) begin
      frame_t e;
      if (frame_done) begin
         done_cnt++;
         check("done_width", 32'(prev_done), 0);
         check("done_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("h_total",   32'(h_total),   e.h_total);
            check("h_active",  32'(h_active),  e.h_active);
            check("v_total",   32'(v_total),   e.v_total);
            check("v_active",  32'(v_active),  e.v_active);
            check("frame_crc", 32'(frame_crc), e.crc);
            check("ovf",       32'(ovf),       e.ovf);
            check("locked",    32'(locked),    e.locked);
            last_exp = e;
         end
      end
      prev_done = frame_done;
   end

   initial begin
      int nl, len, act;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("rst");
      rst = 1'b0;

      // Standard frames: lock after the third latched frame
      for (int f = 0; f < 5; f++) drive_frame(20, 40, 24, 40, 1'b0, -1, -1);
      // Overlong last line saturates hcnt
      drive_frame(20, 40, 24, 70, 1'b0, -1, -1);
      for (int f = 0; f < 3; f++) drive_frame(20, 40, 24, 40, 1'b0, -1, -1);
      // Random geometries
      for (int f = 0; f < 2; f++) begin
         nl  = $urandom_range(16, 24);
         len = $urandom_range(30, 50);
         act = $urandom_range(10, len - 12);
         drive_frame(nl, len, act, len, 1'b0, -1, -1);
      end
      // Constant colour frames: CRC identical every frame
      for (int f = 0; f < 3; f++) drive_frame(20, 40, 24, 40, 1'b1, -1, -1);
      // Reset mid-frame, then recover
      drive_frame(20, 40, 24, 40, 1'b0, 10, -1);
      for (int f = 0; f < 4; f++) drive_frame(20, 40, 24, 40, 1'b0, -1, (f == 2) ? 5 : -1);
      // Final VS rise closes the last frame
      drive_frame(2, 40, 24, 40, 1'b0, -1, -1);
      @(posedge clk);
      #1;
      pxl_cen = 1'b0;
      repeat (4) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 0);
      check("done_count",  32'(done_cnt), 32'(pushed));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
